systolic_out_collector: RTL

Read-out engine for the systolic array's accumulator bank. After an accumulation pass completes, it steps `matrix_index` through every PE row and captures each `mul_outcome` row vector. It requantizes each element to signed `DATA_WIDTH` with round and saturate, then writes the packed row into output SRAM using the same two-word MSB-first packing that the array consumes on `sram_rdata_d0/d1`. It sits between the array's result port and the output/next-layer SRAM.

---
 rtl/systolic_pkg.sv | 19 +
 rtl/out_requant.sv | 12 +
 rtl/systolic_out_collector.sv | 90 +++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared width derivation, collector FSM states and the requantization helper
package systolic_pkg;
  function automatic int headroom(input int k);
    return (k == 1) ? 0 : $clog2(k);
  endfunction
  function automatic int outcome_width(input int dw, input int k);
    return 2 * dw + headroom(k) + 1;
  endfunction
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;
  // 64-bit working width leaves ample room for the rounding add on any legal outcome width
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] x, input int shift, input logic relu, input int dw);
    logic signed [63:0] q, hi, lo;
    q = (x + ((shift > 0) ? (64'sd1 <<< (shift - 1)) : 64'sd0)) >>> shift;
    q = (relu && q < 0) ? 64'sd0 : q;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    return (q > hi) ? hi : (q < lo) ? lo : q;
  endfunction
endpackage

// File: rtl/out_requant.sv
// out_requant: round, optional ReLU and saturate one accumulator element to DW bits
module out_requant import systolic_pkg::*; #(
  parameter int IW = 20,
  parameter int DW = 8,
  parameter int SHIFT = 4,
  parameter int RELU = 0
) (
  input  logic signed [IW-1:0] x,
  output logic        [DW-1:0] q
);
  assign q = DW'(sat_round(64'(x), SHIFT, RELU != 0, DW));
endmodule

// File: rtl/systolic_out_collector.sv
// systolic_out_collector: steps through array rows, requantizes each row and writes it to SRAM
module systolic_out_collector import systolic_pkg::*; #(
  parameter int ARRAY_SIZE = 8,
  parameter int SRAM_DATA_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter int K_ACCUM_DEPTH = 8,
  parameter int SHIFT = 4,
  parameter int RELU = 0,
  parameter int ADDR_WIDTH = 10,
  localparam int OUTCOME_WIDTH = outcome_width(DATA_WIDTH, K_ACCUM_DEPTH)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [ADDR_WIDTH-1:0]               base_addr,
  output logic [5:0]                          matrix_index,
  input  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome,
  output logic                                sram_wen,
  output logic [ADDR_WIDTH-1:0]               sram_waddr,
  output logic [SRAM_DATA_WIDTH-1:0]          sram_wdata0,
  output logic [SRAM_DATA_WIDTH-1:0]          sram_wdata1,
  output logic                                busy,
  output logic                                done
);
  state_e state_q, state_d;
  logic [5:0] row_cnt_q, row_cnt_d, cap_row_q, cap_row_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, waddr_q, waddr_d;
  logic busy_q, busy_d, done_q, done_d, cap_vld_q, cap_vld_d, wen_q, wen_d;
  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] cap_data_q, cap_data_d;
  logic [2*SRAM_DATA_WIDTH-1:0] packed_row, wdata_q, wdata_d;
  logic start_ok, last, drained;
  for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_rq
    out_requant #(.IW(OUTCOME_WIDTH), .DW(DATA_WIDTH), .SHIFT(SHIFT), .RELU(RELU)) u_rq (
      .x(cap_data_q[j*OUTCOME_WIDTH +: OUTCOME_WIDTH]),
      .q(packed_row[2*SRAM_DATA_WIDTH-1-DATA_WIDTH*j -: DATA_WIDTH])
    );
  end
  // next-state for the FSM, the capture stage and the write stage
  always_comb begin
    start_ok = (state_q == IDLE) && start;
    last = row_cnt_q == 6'(ARRAY_SIZE - 1);
    drained = (state_q == DRAIN) && !cap_vld_q;
    state_d = start_ok ? ISSUE : ((state_q == ISSUE) && last) ? DRAIN : drained ? IDLE : state_q;
    row_cnt_d = start_ok ? 6'd0 : ((state_q == ISSUE) && !last) ? row_cnt_q + 6'd1 : row_cnt_q;
    base_d = start_ok ? base_addr : base_q;
    busy_d = start_ok || (busy_q && !drained);
    done_d = drained;
    cap_vld_d = state_q == ISSUE;
    cap_row_d = (state_q == ISSUE) ? row_cnt_q : cap_row_q;
    cap_data_d = (state_q == ISSUE) ? mul_outcome : cap_data_q;
    wen_d = cap_vld_q;
    waddr_d = cap_vld_q ? base_q + ADDR_WIDTH'(cap_row_q) : waddr_q;
    wdata_d = cap_vld_q ? packed_row : wdata_q;
  end
  // all state and registered outputs; reset discards any in-flight row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_cnt_q <= '0;
      base_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cap_vld_q <= 1'b0;
      cap_row_q <= '0;
      cap_data_q <= '0;
      wen_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      row_cnt_q <= row_cnt_d;
      base_q <= base_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cap_vld_q <= cap_vld_d;
      cap_row_q <= cap_row_d;
      cap_data_q <= cap_data_d;
      wen_q <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end
  assign matrix_index = row_cnt_q;
  assign sram_wen = wen_q;
  assign sram_waddr = waddr_q;
  assign sram_wdata0 = wdata_q[2*SRAM_DATA_WIDTH-1 -: SRAM_DATA_WIDTH];
  assign sram_wdata1 = wdata_q[SRAM_DATA_WIDTH-1:0];
  assign busy = busy_q;
  assign done = done_q;
endmodule
